ms_sync_source: RTL and testbench

- Writer end of the master-slave sync link.
- Buffers values from a producer and drives a slave-side integer with a one-cycle sync strobe.
- Its outputs drive a consumer's s_in / s_in_sync pair directly.
- Two-phase controller (section_a / section_b) matches the phase encoding the consumers use.

---
 rtl/ms_sync_source_pkg.sv | 12 +
 rtl/ms_sync_fifo.sv | 56 +++++
 rtl/ms_sync_source.sv | 112 +++++++++++
 tb/tb_ms_sync_source.sv | 135 +++++++++++++
 4 files changed

// File: rtl/ms_sync_source_pkg.sv
// Shared types for the master-slave sync link: phase encoding and default data width.
// Consumer blocks import the same phase definition so both ends agree on encoding.
package ms_sync_source_types;

  localparam int DATA_W_DEFAULT = 32;

  typedef enum logic {
    section_a = 1'b0,
    section_b = 1'b1
  } phases_t;

endpackage

// File: rtl/ms_sync_fifo.sv
// DEPTH x DATA_W circular buffer with push, pop, head and occupancy level.
// The caller guarantees no push while full and no pop while empty.
module ms_sync_fifo
  import ms_sync_source_types::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic signed [DATA_W-1:0]   push_data,
  input  logic                       pop,
  output logic signed [DATA_W-1:0]   head,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic signed [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]         level_q, level_d;

  // Pointers wrap for free because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: storage is not reset; clearing the pointers and level already flushes it.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign level = level_q;

endmodule

// File: rtl/ms_sync_source.sv
// Writer end of the master-slave sync link: buffers producer data and emits one-cycle strobes.
// Optional macro MS_SOURCE_MIN_GAP_EN enforces at least GAP+2 cycles between strobes.
module ms_sync_source
  import ms_sync_source_types::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int DEPTH  = 4,
  parameter int GAP    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [DATA_W-1:0]   m_in,
  input  logic                       m_in_valid,
  output logic                       m_in_ready,
  output logic signed [DATA_W-1:0]   s_out,
  output logic                       s_out_sync,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int LVL_W = $clog2(DEPTH) + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || GAP < 0) begin : g_param_check
    $error("ms_sync_source: DEPTH must be a power of two >= 2 and GAP >= 0");
  end

  phases_t                  phase_q, phase_d;
  logic signed [DATA_W-1:0] s_out_q, s_out_d;
  logic                     sync_q, sync_d;
  logic                     push, pop, gap_ok;
  logic signed [DATA_W-1:0] fifo_head;
  logic [LVL_W-1:0]         fifo_level;

`ifdef MS_SOURCE_MIN_GAP_EN
  localparam int GAP_W = (GAP < 1) ? 1 : $clog2(GAP + 1);
  logic [GAP_W-1:0] gap_q, gap_d;
`endif

  // Ready comes from the registered level only, never from this cycle's pop.
  assign m_in_ready = (fifo_level != LVL_W'(DEPTH));
  assign push       = m_in_valid && m_in_ready;

  ms_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (m_in),
    .pop       (pop),
    .head      (fifo_head),
    .level     (fifo_level)
  );

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    phase_d = phase_q;
    s_out_d = s_out_q;
    sync_d  = 1'b0;
    pop     = 1'b0;
    gap_ok  = 1'b1;
`ifdef MS_SOURCE_MIN_GAP_EN
    gap_d   = gap_q;
`endif
    case (phase_q)
      section_a: begin
`ifdef MS_SOURCE_MIN_GAP_EN
        gap_ok = (gap_q == '0);
        if (!gap_ok) begin
          gap_d = gap_q - GAP_W'(1);
        end
`endif
        if (fifo_level != '0 && gap_ok) begin
          s_out_d = fifo_head;
          sync_d  = 1'b1;
          pop     = 1'b1;
          phase_d = section_b;
        end
      end
      section_b: begin
        phase_d = section_a;
`ifdef MS_SOURCE_MIN_GAP_EN
        gap_d   = GAP_W'(GAP);
`endif
      end
      default: phase_d = section_a;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= section_a;
      s_out_q <= '0;
      sync_q  <= 1'b0;
`ifdef MS_SOURCE_MIN_GAP_EN
      gap_q   <= '0;
`endif
    end else begin
      phase_q <= phase_d;
      s_out_q <= s_out_d;
      sync_q  <= sync_d;
`ifdef MS_SOURCE_MIN_GAP_EN
      gap_q   <= gap_d;
`endif
    end
  end

  assign s_out      = s_out_q;
  assign s_out_sync = sync_q;
  assign level      = fifo_level;

endmodule

// File: tb/tb_ms_sync_source.sv
// Self-checking bench for ms_sync_source: directed scenarios plus random traffic against a queue model.
// The model tracks buffered data in a queue and the edge index of the last transfer.
module tb_ms_sync_source;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int GAP    = 2;
  localparam int LVL_W  = $clog2(DEPTH) + 1;
`ifdef MS_SOURCE_MIN_GAP_EN
  localparam int SPACING = GAP + 2;
`else
  localparam int SPACING = 2;
`endif

  logic                     clk = 1'b0;
  logic                     rst;
  logic signed [DATA_W-1:0] m_in;
  logic                     m_in_valid;
  logic                     m_in_ready;
  logic signed [DATA_W-1:0] s_out;
  logic                     s_out_sync;
  logic [LVL_W-1:0]         level;

  always #5 clk = ~clk;

  ms_sync_source #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .GAP    (GAP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .m_in       (m_in),
    .m_in_valid (m_in_valid),
    .m_in_ready (m_in_ready),
    .s_out      (s_out),
    .s_out_sync (s_out_sync),
    .level      (level)
  );

  int checks = 0;
  int errors = 0;

  logic signed [DATA_W-1:0] model_q [$];
  logic signed [DATA_W-1:0] exp_s_out;
  logic                     exp_sync;
  int                       edge_n    = 0;
  int                       last_load = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, edge_n, got, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model across the coming edge, then compare.
  task automatic step(input logic r, input logic v, input logic signed [DATA_W-1:0] d);
    logic push_ok;
    logic load;
    rst        = r;
    m_in_valid = v;
    m_in       = d;
    if (r) begin
      model_q.delete();
      exp_s_out = '0;
      exp_sync  = 1'b0;
      last_load = edge_n - SPACING;
    end else begin
      push_ok  = v && (model_q.size() != DEPTH);
      load     = (model_q.size() > 0) && (edge_n - last_load >= SPACING);
      exp_sync = load;
      if (load) begin
        exp_s_out = model_q.pop_front();
        last_load = edge_n;
      end
      if (push_ok) model_q.push_back(d);
    end
    @(posedge clk);
    #1;
    edge_n++;
    check("s_out_sync", 64'(s_out_sync), 64'(exp_sync));
    check("s_out", 64'(s_out), 64'(exp_s_out));
    check("level", 64'(level), 64'(model_q.size()));
    check("m_in_ready", 64'(m_in_ready), 64'(model_q.size() != DEPTH));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
  endtask

  initial begin
    // Reset held two cycles with a valid offer present: nothing may be accepted.
    step(1'b1, 1'b1, 32'sd77);
    step(1'b1, 1'b1, 32'sd78);
    idle(2);

    // Single transfer: strobe two cycles after acceptance, value held afterwards.
    step(1'b0, 1'b1, 32'sd5);
    idle(5);

    // Continuous valid 1..8 fills the buffer; back-pressure with same-cycle pop.
    step(1'b1, 1'b0, '0);
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b1, DATA_W'(i));
      while (!m_in_ready) step(1'b0, 1'b1, DATA_W'(i));
    end
    idle(20);

    // Fill to level 3, then reset in the cycle a strobe would fire.
    step(1'b1, 1'b0, '0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, DATA_W'(100 + i));
    step(1'b1, 1'b0, '0);
    idle(8);

    // Three values preloaded back to back: spacing reveals the gap setting.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, -DATA_W'(i + 1));
    idle(16);

    // Random traffic with varying offer density and rare resets.
    for (int seg = 0; seg < 6; seg++) begin
      int pct;
      pct = 20 + seg * 15;
      for (int i = 0; i < 250; i++) begin
        step($urandom_range(0, 199) == 0, $urandom_range(0, 99) < pct, $signed($urandom));
      end
    end
    idle(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
